// File: rtl/ext_imm_pkg.sv
// ext_imm_pkg: shared encodings for the operand-2 / immediate unit.
// Mode and shift-type codes plus the shifter result bundle.
package ext_imm_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        MODE_ROT8   = 3'b000,
        MODE_IMM12  = 3'b001,
        MODE_BR     = 3'b010,
        MODE_SHIFT  = 3'b011,
        MODE_SIMM12 = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shtype_e;

    typedef struct packed {
        logic [MAX_W-1:0] val;
        logic             carry;
        logic             illegal;
    } ext_res_t;

endpackage

// File: rtl/ext_imm_if.sv
// ext_imm_if: request/result handshake bundle for ext_imm_unit.
// master drives requests and out_ready; slave is the unit.
interface ext_imm_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [23:0]       instr;
    logic [2:0]        mode;
    logic [DATA_W-1:0] rm_data;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ext_imm;
    logic              carry_out;
    logic              illegal;

    modport master (
        output in_valid, instr, mode, rm_data, carry_in, out_ready,
        input  in_ready, out_valid, ext_imm, carry_out, illegal
    );

    modport slave (
        input  in_valid, instr, mode, rm_data, carry_in, out_ready,
        output in_ready, out_valid, ext_imm, carry_out, illegal
    );
endinterface

// File: rtl/ext_imm_shifter.sv
// ext_imm_shifter: combinational immediate / shifted-operand datapath.
// Produces the value and ARM shifter carry for every mode.
module ext_imm_shifter
    import ext_imm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [2:0]        mode,
    input  logic [23:0]       instr,
    input  logic [DATA_W-1:0] rm,
    input  logic              carry_in,
    output ext_res_t          res
);
    logic [31:0]              imm8;
    logic [31:0]              rot8;
    logic [4:0]               rot;
    logic [5:0]               rot_inv;
    logic [4:0]               sh;
    logic [5:0]               amt;
    logic [6:0]               ror_inv;
    logic [DATA_W:0]          lsl_t;
    logic [DATA_W:0]          lsr_t;
    logic signed [DATA_W:0]   asr_t;
    logic [DATA_W-1:0]        ror_t;
    logic [DATA_W-1:0]        brx;
    logic [DATA_W-1:0]        immx;
    logic [DATA_W-1:0]        r;
    logic                     c;
    logic                     ill;

    assign imm8    = {24'd0, instr[7:0]};
    assign rot     = {instr[11:8], 1'b0};
    assign rot_inv = 6'd32 - {1'b0, rot};
    assign rot8    = (imm8 >> rot) | (imm8 << rot_inv);

    // shift-by-0 for LSR/ASR encodes a shift of 32
    assign sh      = instr[11:7];
    assign amt     = (sh == 5'd0) ? 6'd32 : {1'b0, sh};
    assign ror_inv = 7'(DATA_W) - {2'b00, sh};

    // extra bit at the far end of each shift catches the carry
    assign lsl_t   = {1'b0, rm} << sh;
    assign lsr_t   = {rm, 1'b0} >> amt;
    assign asr_t   = $signed({rm, 1'b0}) >>> amt;
    assign ror_t   = (rm >> sh) | (rm << ror_inv);

    assign brx     = {{(DATA_W-24){instr[23]}}, instr} << BR_SHIFT;
    assign immx    = {{(DATA_W-12){1'b0}}, instr[11:0]};

    // mode decode: select value and carry
    always_comb begin
        r   = '0;
        c   = carry_in;
        ill = 1'b0;
        case (mode)
            MODE_ROT8: begin
                r[31:0] = rot8;
                c       = (rot == 5'd0) ? carry_in : rot8[31];
            end
            MODE_IMM12:  r = immx;
            MODE_BR:     r = brx;
            MODE_SIMM12: r = instr[23] ? immx : -immx;
            MODE_SHIFT: begin
                case (instr[6:5])
                    SH_LSL: begin
                        if (sh != 5'd0) begin
                            r = lsl_t[DATA_W-1:0];
                            c = lsl_t[DATA_W];
                        end else begin
                            r = rm;
                        end
                    end
                    SH_LSR: begin
                        r = lsr_t[DATA_W:1];
                        c = lsr_t[0];
                    end
                    SH_ASR: begin
                        r = asr_t[DATA_W:1];
                        c = asr_t[0];
                    end
                    default: begin
                        if (sh == 5'd0) begin
                            r = {carry_in, rm[DATA_W-1:1]};
                            c = rm[0];
                        end else begin
                            r = ror_t;
                            c = ror_t[DATA_W-1];
                        end
                    end
                endcase
            end
            default: ill = 1'b1;
        endcase
    end

    // pack into the shared result bundle
    always_comb begin
        res                   = '0;
        res.val[DATA_W-1:0]   = r;
        res.carry             = c;
        res.illegal           = ill;
    end

endmodule

// File: rtl/ext_imm_unit.sv
// ext_imm_unit: two-stage operand-2 / immediate pipeline.
// Stage 1 holds the request, stage 2 holds the computed result.
module ext_imm_unit
    import ext_imm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input logic      clk,
    input logic      rst_n,
    input logic      flush,
    ext_imm_if.slave bus
);
    logic              s1_valid;
    logic [23:0]       s1_instr;
    logic [2:0]        s1_mode;
    logic [DATA_W-1:0] s1_rm;
    logic              s1_cin;
    logic              out_valid_q;
    logic [DATA_W-1:0] ext_imm_q;
    logic              carry_q;
    logic              illegal_q;
    logic              s2_adv;
    logic              s1_take;
    ext_res_t          res;
    logic              unused_hi;

    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !flush && (!s1_valid || s2_adv);
    assign s1_take      = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.ext_imm   = ext_imm_q;
    assign bus.carry_out = carry_q;
    assign bus.illegal   = illegal_q;

    ext_imm_shifter #(
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_shifter (
        .mode     (s1_mode),
        .instr    (s1_instr),
        .rm       (s1_rm),
        .carry_in (s1_cin),
        .res      (res)
    );

    assign unused_hi = ^res.val;

    // stage 1: capture request, empty when its entry moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_mode  <= '0;
            s1_rm    <= '0;
            s1_cin   <= 1'b0;
        end else begin
            if (flush)        s1_valid <= 1'b0;
            else if (s1_take) s1_valid <= 1'b1;
            else if (s2_adv)  s1_valid <= 1'b0;
            if (s1_take) begin
                s1_instr <= bus.instr;
                s1_mode  <= bus.mode;
                s1_rm    <= bus.rm_data;
                s1_cin   <= bus.carry_in;
            end
        end
    end

    // stage 2: register result, hold while consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ext_imm_q   <= '0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                ext_imm_q <= res.val[DATA_W-1:0];
                carry_q   <= res.carry;
                illegal_q <= res.illegal;
            end
        end
    end

endmodule

// File: doc/ext_imm_unit.md
Name: ext_imm_unit

Overview:
Pipelined operand-2 / immediate generator for the ARM-style datapath, replacing the combinational extender.
- Produces rotated imm8, zero/signed imm12, scaled branch offsets and immediate-shifted register operands, each with ARM shifter carry-out.
- Sits between decode and the ALU/address path.
- Two-stage valid/ready pipeline with flush.

Parameters:
DATA_W, 32, result width; legal values 32 or 64; immediates are extended to DATA_W.
BR_SHIFT, 2, left shift applied to the sign-extended 24-bit branch field.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline clear; wins over everything else
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
instr  in  24  instruction bits [23:0]
mode  in  3  000 rot-imm8, 001 zext imm12, 010 branch, 011 reg shift-by-imm5, 100 signed imm12 (U=instr[23])
rm_data  in  DATA_W  register operand for mode 011
carry_in  in  1  current CPSR C flag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
ext_imm  out  DATA_W  result
carry_out  out  1  shifter carry
illegal  out  1  mode 101..111 was used (result 0, carry_out = carry_in)

Behaviour:
- Reset: in_ready=1, out_valid=0, ext_imm=0, carry_out=0, illegal=0, and all internal valid bits cleared.
- Stage 1 (s1):
  - Captures instr, mode, rm_data and carry_in when in_valid && in_ready.
  - in_ready = !flush && (!s1_valid || s2_adv), where s2_adv = !out_valid || out_ready.
- Stage 2 (s2):
  - Computes the result and registers it into the output registers when s1_valid && s2_adv.
  - out_valid drops when out_ready is high and s1 has nothing to move.
- Timing: acceptance at edge N gives out_valid=1 after edge N+1; latency is 2 edges. Throughput is 1 per cycle when out_ready stays high.
- Backpressure: with out_ready=0, the outputs are held stable and s1 is held. in_ready=0 once s1 is full. No data loss or duplication.
- Flush: at the next edge, s1_valid and out_valid are cleared. Any input presented in the flush cycle is not accepted, because in_ready=0.
- Mode 000 (rot-imm8):
  - Rotate = instr[11:8]*2. The result is the 32-bit ROR of zext(instr[7:0]), then zero-extended to DATA_W.
  - carry_out = carry_in when rotate = 0, else result[31].
- Mode 001: result = zext(instr[11:0]); carry_out = carry_in.
- Mode 010: result = sext(instr[23:0]) << BR_SHIFT, truncated to DATA_W; carry_out = carry_in.
- Mode 011 (shift-by-imm5): sh = instr[11:7], type = instr[6:5], applied to rm_data over DATA_W bits.
  - LSL: sh=0 gives rm, carry_in. Otherwise rm<<sh, carry = rm[DATA_W-sh].
  - LSR: sh=0 means a shift of 32. For DATA_W=32 that gives result 0, carry rm[31]. Otherwise rm>>sh, carry rm[sh-1].
  - ASR: sh=0 means a shift of 32. For DATA_W=32 the result is all rm[MSB], carry rm[MSB]. Otherwise arithmetic shift, carry rm[sh-1].
  - ROR: sh=0 means RRX, result {carry_in, rm[DATA_W-1:1]}, carry rm[0]. Otherwise rotate over DATA_W, carry = result[MSB].
  - For DATA_W=64, shift-of-32 applies literally: LSR gives rm>>32 with carry rm[31].
- Mode 100: result = instr[23] ? zext(imm12) : -zext(imm12), two's complement in DATA_W; carry_out = carry_in.
- Reset asserted mid-operation: all valid bits clear immediately (asynchronous). Pending requests are lost.

Decomposition:
- Package ext_imm_pkg holds:
  - mode encodings: MODE_ROT8, MODE_IMM12, MODE_BR, MODE_SHIFT, MODE_SIMM12;
  - shift-type encodings: SH_LSL, SH_LSR, SH_ASR, SH_ROR;
  - a result+carry struct.
- One combinational sub-module, ext_imm_shifter, computes result and carry from mode, instr, rm, carry_in and DATA_W. The top-level module holds only the pipeline registers and handshake.

Test Plan:
- Mode 000, instr=0x000_2FF (rot 4), carry_in=0 -> ext_imm=0xF000000F, carry_out=1, out_valid exactly 2 edges after acceptance.
- Mode 010, instr=0xFFFFFE -> ext_imm=0xFFFFFFF8; mode 100, instr=0x000004 -> 0xFFFFFFFC; mode 001, instr=0x000ABC -> 0x00000ABC.
- Mode 011 specials:
  - rm=0x80000001, LSR#0 -> 0, carry 1;
  - same rm, ASR#0 -> 0xFFFFFFFF, carry 1;
  - same rm, ROR#0 with carry_in=1 -> 0xC0000000, carry 1;
  - LSL#0 with carry_in=0 -> 0x80000001, carry 0.
- Back-to-back stream of 8 requests with out_ready toggled 1,0,0,1,... -> every result delivered once, in order; outputs stable while stalled; in_ready low only when both stages are full.
- flush asserted with s1 and output both valid and in_valid high -> out_valid=0 next cycle; the flush-cycle request is not accepted; the next request completes normally.
- mode=111 -> illegal=1, ext_imm=0, carry_out=carry_in. Reset pulse mid-stream -> all outputs return to reset values immediately.
